mem_responder: RTL

- Memory-side responder for the core's instruction-fetch and load/store request interface.
- Accepts one request at a time over a valid/ready handshake and holds a word-addressed SRAM array.
- Returns read data or a write acknowledge after a programmable latency, so IFU/LSU can move from ideal memory to multi-cycle memory.
- One instance serves IFU; a second instance, or one behind an arbiter, serves LSU.

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_lfsr8.sv | 27 ++
 rtl/mem_responder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared FSM encoding, address default and LFSR constants for mem_responder
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int          DEFAULT_WIDTH     = 32;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam int          MASK_W            = DEFAULT_WIDTH / 8;

  // Fibonacci taps 8,6,5,4 expressed as a mask over q[7:0]
  localparam logic [7:0]  LFSR_SEED = 8'hA5;
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;

  function automatic int mask_w(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between a requester and mem_responder
interface mem_responder_if #(
  parameter int WIDTH = 32
) ();

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [WIDTH-1:0]   req_addr;
  logic [WIDTH-1:0]   req_wdata;
  logic [WIDTH/8-1:0] req_wmask;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_lfsr8.sv
// rtl/mem_lfsr8.sv - 8-bit Fibonacci LFSR with enable, exposing its low OUT_W bits
module mem_lfsr8
  import mem_bus_pkg::*;
#(
  parameter logic [7:0] SEED  = LFSR_SEED,
  parameter int         OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [OUT_W-1:0] q_low
);

  logic [7:0] q;

  assign q_low = q[OUT_W-1:0];

  // shift left, feeding back the XOR of the tapped stages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - SRAM-backed responder with programmable latency (MEM_RESPONDER_RAND_DELAY_EN adds 0..7 random cycles)
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH_LOG2 = 12,
  parameter logic [WIDTH-1:0] BASE_ADDR  = WIDTH'(DEFAULT_BASE_ADDR),
  parameter int               LATENCY    = 1
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int               MW    = mask_w(WIDTH);
  localparam int               DEPTH = 1 << DEPTH_LOG2;
  localparam logic [WIDTH-1:0] SPAN  = WIDTH'(DEPTH * 4);

  logic [WIDTH-1:0] mem [DEPTH];

  state_e                state;
  logic [4:0]            cnt;
  logic                  lat_we;
  logic [WIDTH-1:0]      lat_addr;
  logic [WIDTH-1:0]      lat_wdata;
  logic [MW-1:0]         lat_wmask;
  logic [WIDTH-1:0]      rsp_rdata_q;
  logic                  rsp_err_q;

  logic                  accept;
  logic                  go_resp;
  logic [4:0]            extra;
  logic [4:0]            total;
  logic                  c_we;
  logic [WIDTH-1:0]      c_addr;
  logic [WIDTH-1:0]      c_wdata;
  logic [MW-1:0]         c_wmask;
  logic [WIDTH-1:0]      off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic                  mem_wr;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept = bus.req_valid && (state == IDLE);

`ifdef MEM_RESPONDER_RAND_DELAY_EN
  logic [2:0] rand_low;

  mem_lfsr8 #(
    .SEED  (LFSR_SEED),
    .OUT_W (3)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (accept),
    .q_low (rand_low)
  );

  assign extra = {2'b00, rand_low};
`else
  assign extra = 5'd0;
`endif

  assign total = 5'(LATENCY) + extra;

  // With a one-cycle latency the commit happens on the acceptance edge, so use the live request
  assign c_we    = (state == IDLE) ? bus.req_we    : lat_we;
  assign c_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
  assign c_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
  assign c_wmask = (state == IDLE) ? bus.req_wmask : lat_wmask;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the unsigned compare
  assign off      = c_addr - BASE_ADDR;
  assign in_range = off < SPAN;
  assign c_idx    = off[DEPTH_LOG2+1:2];

  assign go_resp = (accept && total == 5'd1) || (state == WAIT && cnt == 5'd1);
  assign mem_wr  = go_resp && c_we && in_range;

  // Byte-lane write into the array on the commit edge; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < MW; b++) begin
        if (c_wmask[b]) begin
          mem[c_idx][b*8 +: 8] <= c_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Request/response FSM: latch on accept, count down, commit, hold response until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_wmask   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_wmask <= bus.req_wmask;
            if (total == 5'd1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= total - 5'd1;
            end
          end
        end
        WAIT: begin
          if (cnt == 5'd1) begin
            state <= RESP;
            cnt   <= 5'd0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state     <= IDLE;
            rsp_err_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        rsp_err_q   <= !in_range;
        rsp_rdata_q <= (!c_we && in_range) ? mem[c_idx] : '0;
      end
    end
  end

endmodule
